// File: rtl/lutk_slice_pkg.sv
// Shared definitions for the LUT-K slice: per-cell configuration field layout.
// The truth table sits at the bottom of each cell field. The four control
// bits follow it, and their offsets below are counted from the end of the table.
package lutk_slice_pkg;

    localparam int OFS_TABLE    = 0;
    localparam int OFS_OUT_MUX  = 0;
    localparam int OFS_I0MUX    = 1;
    localparam int OFS_RST_VAL  = 2;
    localparam int OFS_SRL_MODE = 3;

    // Bits per cell: 2**k truth-table bits plus four control bits.
    function automatic int cell_width(input int k);
        return (1 << k) + 4;
    endfunction

endpackage

// File: rtl/fpga_outbuf.sv
// Library output buffer: forces the output low when it is disabled.
module fpga_outbuf (
    input  logic I,
    input  logic EN,
    output logic O
);
    assign O = I & EN;
endmodule

// File: rtl/lutk_cell.sv
// One LUT-K cell: I0/carry mux, table lookup, carry majority, output flop and,
// when LUTK_SLICE_SRL_EN is defined, a shift-register table with its cascade.
module lutk_cell
    import lutk_slice_pkg::*;
#(
    parameter int K = 4
) (
    input  logic                     UserCLK,
    input  logic                     SR,
    input  logic                     EN,
    input  logic [K-1:0]             I,
    input  logic                     carry_in,
    output logic                     carry_out,
    input  logic                     SE,
    input  logic                     srl_din,
    output logic                     srl_msb,
    input  logic                     OutputEnable,
    input  logic [cell_width(K)-1:0] cfg,
    output logic                     O
);
    localparam int T = 2**K;

    logic [T-1:0] cfg_table;
    logic [T-1:0] lut_table;
    logic         c_out_mux, c_i0mux, c_reset_value, c_srl_mode;
    logic         lut_i0, lut_out, flop_q, o_pre, i2;
    logic [K-1:0] lut_idx;

    assign cfg_table     = cfg[OFS_TABLE +: T];
    assign c_out_mux     = cfg[T + OFS_OUT_MUX];
    assign c_i0mux       = cfg[T + OFS_I0MUX];
    assign c_reset_value = cfg[T + OFS_RST_VAL];
    assign c_srl_mode    = cfg[T + OFS_SRL_MODE];

    my_mux2 u_i0_mux (.A0(I[0]), .A1(carry_in), .S(c_i0mux), .X(lut_i0));

    assign lut_idx = {I[K-1:1], lut_i0};
    assign lut_out = lut_table[lut_idx];

    // A two-input cell has no I2; treat it as 0 so the carry reduces to AND.
    if (K > 2) begin : g_i2
        assign i2 = I[2];
    end else begin : g_no_i2
        assign i2 = 1'b0;
    end

    assign carry_out = (carry_in & I[1]) | (carry_in & i2) | (I[1] & i2);

    // Output flop: reset value has priority over the clock enable.
    always_ff @(posedge UserCLK) begin
        if (SR)
            flop_q <= c_reset_value;
        else if (EN)
            flop_q <= lut_out;
    end

`ifdef LUTK_SLICE_SRL_EN
    logic [T-1:0] srl_q;

    // Shift register: reloads the static table on reset; otherwise it shifts on SE
    // in every cell so the cascade passes through cells not in SRL mode.
    always_ff @(posedge UserCLK) begin
        if (SR)
            srl_q <= cfg_table;
        else if (SE)
            srl_q <= {srl_q[T-2:0], srl_din};
    end

    assign lut_table = c_srl_mode ? srl_q : cfg_table;
    assign srl_msb   = srl_q[T-1];
`else
    logic unused_srl;

    assign lut_table  = cfg_table;
    assign srl_msb    = 1'b0;
    assign unused_srl = ^{SE, srl_din, c_srl_mode};
`endif

    my_mux2     u_out_mux (.A0(lut_out), .A1(flop_q), .S(c_out_mux), .X(o_pre));
    fpga_outbuf u_obuf    (.I(o_pre), .EN(OutputEnable), .O(O));

endmodule

// File: rtl/my_mux2.sv
// Library 2:1 mux cell, reused for the I0 select and the output select.
module my_mux2 (
    input  logic A0,
    input  logic A1,
    input  logic S,
    output logic X
);
    assign X = S ? A1 : A0;
endmodule

// File: rtl/lutk_slice_frame_config.sv
// Slice of N_LUTS LUT-K cells with a combinational carry chain and an optional
// SRL cascade (compiled in by LUTK_SLICE_SRL_EN), configured from a static frame.
module lutk_slice_frame_config
    import lutk_slice_pkg::*;
#(
    parameter int LUT_SIZE     = 4,
    parameter int N_LUTS       = 2,
    parameter int NoConfigBits = N_LUTS * (2**LUT_SIZE + 4)
) (
    input  logic                       UserCLK,
    input  logic                       SR,
    input  logic                       EN,
    input  logic [N_LUTS*LUT_SIZE-1:0] I,
    input  logic                       Ci,
    output logic                       Co,
    input  logic                       SE,
    input  logic                       SRL_D,
    output logic                       SRL_Q,
    output logic [N_LUTS-1:0]          O,
    input  logic                       OutputEnable,
    input  logic [NoConfigBits-1:0]    ConfigBits
);
    localparam int W = cell_width(LUT_SIZE);

    if (LUT_SIZE < 2 || LUT_SIZE > 6) begin : g_bad_k
        $error("LUT_SIZE must be within 2..6");
    end
    if (N_LUTS < 1 || N_LUTS > 8) begin : g_bad_n
        $error("N_LUTS must be within 1..8");
    end
    if (NoConfigBits != N_LUTS * W) begin : g_bad_cfg
        $error("NoConfigBits does not match N_LUTS*(2**LUT_SIZE+4)");
    end

    logic [N_LUTS:0] carry;
    logic [N_LUTS:0] srl_chain;

    assign carry[0]     = Ci;
    assign srl_chain[0] = SRL_D;

    for (genvar j = 0; j < N_LUTS; j++) begin : g_cell
        lutk_cell #(.K(LUT_SIZE)) u_cell (
            .UserCLK      (UserCLK),
            .SR           (SR),
            .EN           (EN),
            .I            (I[j*LUT_SIZE +: LUT_SIZE]),
            .carry_in     (carry[j]),
            .carry_out    (carry[j+1]),
            .SE           (SE),
            .srl_din      (srl_chain[j]),
            .srl_msb      (srl_chain[j+1]),
            .OutputEnable (OutputEnable),
            .cfg          (ConfigBits[j*W +: W]),
            .O            (O[j])
        );
    end

    assign Co    = carry[N_LUTS];
    assign SRL_Q = srl_chain[N_LUTS];

endmodule
